nubus_master_seq: RTL and testbench
===================================

Name: nubus_master_seq

Overview:
Sequences the NuBus glue for master-mode transactions on behalf of the FPGA bus master. It enforces fair request and runs arbitration through the arbiter (arbcy_n/grant). It waits for the bus to go idle, steers the master-direction and output-enable controls for the START cycle, and waits for ACK with a timeout. It sits between the FPGA master engine and the 5V glue/arbiter logic, and is the only block that drives rqst_oe_n, arbcy_n and nubus_master_dir.

Parameters:
ARB_CYCLES, 2, clocks arbcy_n held low before grant is sampled (NuBus arbitration settle)
TIMEOUT, 255, clocks in WAIT_ACK before the transaction is abandoned
TCNT_W, 8, width of the shared cycle counter; must hold max(ARB_CYCLES, TIMEOUT)

Ports:
nubus_clk  in  1  NuBus clock; all state changes on rising edge
nubus_rst  in  1  synchronous, active-high reset
mst_req  in  1  master engine requests a transaction; level, held until mst_done
mst_lock  in  1  keep bus ownership after this transaction (RQST held through START)
start_n_3v3  in  1  sampled NuBus START (low = start cycle on bus)
ack_n_3v3  in  1  sampled NuBus ACK
rqst_n_3v3  in  1  sampled NuBus RQST (wired-OR, any card)
tm_n_3v3  in  2  sampled TM1:TM0 during ACK (status)
grant  in  1  arbiter result: this card won
rqst_oe_n  out  1  low = drive our RQST onto bus
arbcy_n  out  1  low = arbiter contests
nubus_master_dir  out  1  high = START driven by this card
start_n_o  out  1  START value to glue (low in START state only)
mst_busy  out  1  high from leaving IDLE until DONE
mst_done  out  1  one-clock pulse at end of transaction
mst_err  out  1  valid with mst_done: timeout or non-zero error status
mst_status  out  2  valid with mst_done: captured ~tm_n_3v3 (00 = success)

Behaviour:
- All outputs registered. Reset values: rqst_oe_n=1, arbcy_n=1, nubus_master_dir=0, start_n_o=1, mst_busy=0, mst_done=0, mst_err=0, mst_status=00, state=IDLE, counter=0, bus_busy=0.
- bus_busy tracker, independent of the FSM: set when start_n_3v3=0 and this card is not in START; cleared when ack_n_3v3=0. On simultaneous set and clear, clear wins (single-cycle transfer).
- IDLE: if mst_req=1, go to FAIR.
- FAIR: wait until rqst_n_3v3=1 (fairness: no other requester pending), then go to ARB with counter=0. Skip this wait when our own locked RQST is still asserted.
- ARB: rqst_oe_n=0, arbcy_n=0. Counter increments each clock. When counter=ARB_CYCLES-1, sample grant: if grant=1, go to WAIT_IDLE; if 0, hold RQST, restart the counter, and stay in ARB (re-contest). arbcy_n returns to 1 on exit.
- WAIT_IDLE: RQST stays asserted. When bus_busy=0 and start_n_3v3=1, go to START. If grant drops while waiting, return to ARB.
- START, exactly one clock: nubus_master_dir=1, start_n_o=0. rqst_oe_n goes to 1 in this same cycle unless mst_lock=1. Go to WAIT_ACK with counter=0.
- WAIT_ACK: nubus_master_dir=0, start_n_o=1. Counter increments each clock.
  - On ack_n_3v3=0: capture mst_status=~tm_n_3v3, set mst_err=(status!=00), go to DONE.
  - If the counter reaches TIMEOUT-1 with no ack: set mst_err=1, mst_status=11, go to DONE.
  - An ACK in the same cycle as the timeout wins.
- DONE: mst_done=1 for one clock, then IDLE. If mst_lock=1 and mst_req is still high, go directly to WAIT_IDLE with RQST held; this skips FAIR and ARB because ownership is retained.
- Counter saturates and never wraps. Width violations of TCNT_W are a parameter error: assert in simulation.
- mst_req dropping before START aborts: release RQST and arbcy_n and return to IDLE with no mst_done. After START, a drop of mst_req is ignored.
- Reset mid-transaction: all outputs return to their reset values on the next edge. There is no partial START.

Decomposition:
- Package nubus_seq_pkg: state enum (IDLE, FAIR, ARB, WAIT_IDLE, START, WAIT_ACK, DONE), TM status constants (TM_OK=00, TM_ERR=01, TM_RETRY=10, TM_TMO=11), default ARB_CYCLES and TIMEOUT.
- One sub-module: nubus_bus_monitor (the bus_busy tracker), reused by the slave path later.

Test Plan:
- Idle bus, grant=1 after 2 clocks: mst_req pulse -> arbcy_n low for 2 clocks, start_n_o low for exactly 1 clock at cycle 4 after req, rqst_oe_n high in that START cycle; ack with tm=00 three clocks later -> mst_done=1, mst_err=0, mst_status=00.
- rqst_n_3v3=0 (another card pending) for 10 clocks -> stay in FAIR with rqst_oe_n=1 throughout; arbitration starts the clock after release.
- grant=0 on first contest, 1 on second -> ARB repeats, a single START is issued, and RQST is never released between the contests.
- Foreign transaction in progress (start_n_3v3 low, ack 5 clocks later) while granted -> START is issued only after the ack is observed.
- No ACK -> mst_done after 255 WAIT_ACK clocks with mst_err=1, mst_status=11. A separate run with ACK tm=10 -> mst_err=1, mst_status=10.
- mst_lock=1 with back-to-back requests -> second START follows with no FAIR/ARB and rqst_oe_n stays low. nubus_rst asserted during WAIT_ACK -> all outputs reach reset values on the next edge.

Source files
------------

// File: rtl/nubus_seq_pkg.sv
// Shared types and constants for the NuBus master/slave sequencers.
// Contents:
//   state_e        - master sequencer FSM states
//   TM_*           - TM1:TM0 status codes as captured (inverted from the bus)
//   *_DEF          - default timing parameters
package nubus_seq_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StFair,
        StArb,
        StWaitIdle,
        StStart,
        StWaitAck,
        StDone
    } state_e;

    localparam logic [1:0] TM_OK    = 2'b00;
    localparam logic [1:0] TM_ERR   = 2'b01;
    localparam logic [1:0] TM_RETRY = 2'b10;
    localparam logic [1:0] TM_TMO   = 2'b11;

    localparam int unsigned ARB_CYCLES_DEF = 2;
    localparam int unsigned TIMEOUT_DEF    = 255;
    localparam int unsigned TCNT_W_DEF     = 8;

endpackage

// File: rtl/nubus_bus_monitor.sv
// Tracks whether some other card owns a NuBus transaction in progress.
// Ports:
//   clk_i        - NuBus clock
//   rst_i        - synchronous active-high reset
//   start_n_i    - sampled START (low = start cycle)
//   ack_n_i      - sampled ACK (low = transaction ends)
//   own_start_i  - this card is driving START this cycle; ignore it
//   bus_busy_o   - registered busy flag
module nubus_bus_monitor (
    input  logic clk_i,
    input  logic rst_i,
    input  logic start_n_i,
    input  logic ack_n_i,
    input  logic own_start_i,
    output logic bus_busy_o
);

    logic busy_q, busy_d;

    // ACK has priority so a START+ACK single-cycle transfer leaves the bus idle.
    always_comb begin
        busy_d = busy_q;
        if (!ack_n_i) begin
            busy_d = 1'b0;
        end else if (!start_n_i && !own_start_i) begin
            busy_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            busy_q <= 1'b0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign bus_busy_o = busy_q;

endmodule

// File: rtl/nubus_master_seq.sv
// NuBus master-mode sequencer: fair request, arbitration, bus-idle wait,
// START generation and ACK wait with timeout. All outputs are registered.
// Ports:
//   nubus_clk, nubus_rst         - clock, synchronous active-high reset
//   mst_req, mst_lock            - master engine request / keep-ownership
//   start_n_3v3, ack_n_3v3,
//   rqst_n_3v3, tm_n_3v3         - sampled NuBus signals
//   grant                        - arbiter says this card won
//   rqst_oe_n, arbcy_n,
//   nubus_master_dir, start_n_o  - glue/arbiter controls
//   mst_busy, mst_done,
//   mst_err, mst_status          - status back to the master engine
module nubus_master_seq
    import nubus_seq_pkg::*;
#(
    parameter int unsigned ARB_CYCLES = ARB_CYCLES_DEF,
    parameter int unsigned TIMEOUT    = TIMEOUT_DEF,
    parameter int unsigned TCNT_W     = TCNT_W_DEF
) (
    input  logic       nubus_clk,
    input  logic       nubus_rst,
    input  logic       mst_req,
    input  logic       mst_lock,
    input  logic       start_n_3v3,
    input  logic       ack_n_3v3,
    input  logic       rqst_n_3v3,
    input  logic [1:0] tm_n_3v3,
    input  logic       grant,
    output logic       rqst_oe_n,
    output logic       arbcy_n,
    output logic       nubus_master_dir,
    output logic       start_n_o,
    output logic       mst_busy,
    output logic       mst_done,
    output logic       mst_err,
    output logic [1:0] mst_status
);

    localparam logic [TCNT_W-1:0] ArbLast = TCNT_W'(ARB_CYCLES - 1);
    localparam logic [TCNT_W-1:0] TmoLast = TCNT_W'(TIMEOUT - 1);

    localparam bit ParamsOk = (ARB_CYCLES >= 1) && (TIMEOUT >= 1) && (TCNT_W <= 32) &&
                              (64'(ARB_CYCLES) <= (64'd1 << TCNT_W)) &&
                              (64'(TIMEOUT) <= (64'd1 << TCNT_W));

`ifndef SYNTHESIS
    always_ff @(posedge nubus_clk) begin
        assert (ParamsOk)
        else $error("nubus_master_seq: ARB_CYCLES/TIMEOUT do not fit in TCNT_W");
    end
`endif

    state_e            state_q, state_d;
    logic [TCNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic              rqst_oe_n_q, rqst_oe_n_d;
    logic              arbcy_n_q, arbcy_n_d;
    logic              dir_q, dir_d;
    logic              start_n_q, start_n_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [1:0]        status_q, status_d;
    logic              bus_busy;

    nubus_bus_monitor u_bus_monitor (
        .clk_i       (nubus_clk),
        .rst_i       (nubus_rst),
        .start_n_i   (start_n_3v3),
        .ack_n_i     (ack_n_3v3),
        .own_start_i (state_q == StStart),
        .bus_busy_o  (bus_busy)
    );

    // Saturating increment: the counter never wraps.
    assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

    // Next-state logic.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        status_d = status_q;
        unique case (state_q)
            StIdle: begin
                if (mst_req) state_d = StFair;
            end
            StFair: begin
                // A still-held locked RQST makes rqst_n_3v3 low by ourselves.
                if (!mst_req) begin
                    state_d = StIdle;
                end else if (rqst_n_3v3 || !rqst_oe_n_q) begin
                    state_d = StArb;
                    cnt_d   = '0;
                end
            end
            StArb: begin
                if (!mst_req) begin
                    state_d = StIdle;
                end else if (cnt_q == ArbLast) begin
                    cnt_d = '0;
                    if (grant) state_d = StWaitIdle;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            StWaitIdle: begin
                if (!mst_req) begin
                    state_d = StIdle;
                end else if (!grant) begin
                    state_d = StArb;
                    cnt_d   = '0;
                end else if (!bus_busy && start_n_3v3) begin
                    state_d = StStart;
                end
            end
            StStart: begin
                state_d = StWaitAck;
                cnt_d   = '0;
            end
            StWaitAck: begin
                cnt_d = cnt_inc;
                // ACK is tested first so it wins over a coincident timeout.
                if (!ack_n_3v3) begin
                    status_d = ~tm_n_3v3;
                    err_d    = (~tm_n_3v3 != TM_OK);
                    state_d  = StDone;
                end else if (cnt_q == TmoLast) begin
                    status_d = TM_TMO;
                    err_d    = 1'b1;
                    state_d  = StDone;
                end
            end
            StDone: begin
                state_d = (mst_lock && mst_req) ? StWaitIdle : StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Registered outputs are decoded from the next state so they line up with it.
    always_comb begin
        arbcy_n_d = (state_d != StArb);
        dir_d     = (state_d == StStart);
        start_n_d = (state_d != StStart);
        busy_d    = (state_d != StIdle);
        done_d    = (state_d == StDone);
        unique case (state_d)
            StArb, StWaitIdle: rqst_oe_n_d = 1'b0;
            StStart:           rqst_oe_n_d = !mst_lock;
            StFair, StWaitAck,
            StDone:            rqst_oe_n_d = rqst_oe_n_q;
            // Locked ownership survives into IDLE; an abort always releases.
            StIdle: rqst_oe_n_d = (mst_lock && (state_q == StIdle || state_q == StDone)) ?
                                  rqst_oe_n_q : 1'b1;
            default:           rqst_oe_n_d = 1'b1;
        endcase
    end

    always_ff @(posedge nubus_clk) begin
        if (nubus_rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            rqst_oe_n_q <= 1'b1;
            arbcy_n_q   <= 1'b1;
            dir_q       <= 1'b0;
            start_n_q   <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            status_q    <= TM_OK;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rqst_oe_n_q <= rqst_oe_n_d;
            arbcy_n_q   <= arbcy_n_d;
            dir_q       <= dir_d;
            start_n_q   <= start_n_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            status_q    <= status_d;
        end
    end

    assign rqst_oe_n        = rqst_oe_n_q;
    assign arbcy_n          = arbcy_n_q;
    assign nubus_master_dir = dir_q;
    assign start_n_o        = start_n_q;
    assign mst_busy         = busy_q;
    assign mst_done         = done_q;
    assign mst_err          = err_q;
    assign mst_status       = status_q;

endmodule

// File: tb/tb_nubus_master_seq.sv
module tb_nubus_master_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       req, lock, start_n, ack_n, rqst_n, grant;
    logic [1:0] tm_n;
    logic       rqst_oe_n, arbcy_n, dir, start_n_o, busy, done, err;
    logic [1:0] status;

    int errors = 0;
    int checks = 0;

    // {rqst_oe_n, arbcy_n, dir, start_n_o, busy, done, err, status}
    localparam logic [8:0] RST_VEC = 9'b1_1_0_1_0_0_0_00;

    always #5 clk = ~clk;

    nubus_master_seq dut (
        .nubus_clk        (clk),
        .nubus_rst        (rst),
        .mst_req          (req),
        .mst_lock         (lock),
        .start_n_3v3      (start_n),
        .ack_n_3v3        (ack_n),
        .rqst_n_3v3       (rqst_n),
        .tm_n_3v3         (tm_n),
        .grant            (grant),
        .rqst_oe_n        (rqst_oe_n),
        .arbcy_n          (arbcy_n),
        .nubus_master_dir (dir),
        .start_n_o        (start_n_o),
        .mst_busy         (busy),
        .mst_done         (done),
        .mst_err          (err),
        .mst_status       (status)
    );

    function automatic logic [8:0] outs();
        return {rqst_oe_n, arbcy_n, dir, start_n_o, busy, done, err, status};
    endfunction

    // Inputs change and outputs are sampled at the falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic defaults();
        req = 0; lock = 0; start_n = 1; ack_n = 1; rqst_n = 1; grant = 1; tm_n = 2'b11;
    endtask

    // Waits (bounded) for START, acks one clock later with tm_n, returns
    // {done, err, status} seen in the DONE cycle and the number of START cycles.
    task automatic finish_txn(input logic [1:0] tmn, output logic [3:0] res, output int starts);
        bit seen = 0;
        starts = 0;
        res = '0;
        for (int i = 0; i < 40; i++) begin
            if (start_n_o === 1'b0) begin
                seen = 1;
                break;
            end
            step();
        end
        if (seen) begin
            starts = 1;
            step();
            ack_n = 0;
            tm_n = tmn;
            step();
            res = {done, err, status};
            if (start_n_o === 1'b0) starts++;
        end
        ack_n = 1;
        tm_n = 2'b11;
        req = 0;
        step();
    endtask

    task automatic wait_start(output bit seen);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (start_n_o === 1'b0) begin
                seen = 1;
                return;
            end
            step();
        end
    endtask

    task automatic test_reset();
        defaults();
        rst = 1;
        repeat (3) step();
        checks++;
        if (outs() !== RST_VEC) begin
            errors++; $display("FAIL reset_values: got %b want %b", outs(), RST_VEC);
        end
        rst = 0;
        step();
        checks++;
        if (outs() !== RST_VEC) begin
            errors++; $display("FAIL idle_after_reset: got %b want %b", outs(), RST_VEC);
        end
    endtask

    task automatic test_basic();
        defaults();
        req = 1;
        step(); // FAIR
        checks++;
        if ({rqst_oe_n, arbcy_n, busy} !== 3'b111) begin
            errors++; $display("FAIL basic_fair: got %b want 111", {rqst_oe_n, arbcy_n, busy});
        end
        for (int c = 0; c < 2; c++) begin
            step(); // ARB
            checks++;
            if ({rqst_oe_n, arbcy_n} !== 2'b00) begin
                errors++; $display("FAIL basic_arb%0d: got %b want 00", c, {rqst_oe_n, arbcy_n});
            end
        end
        step(); // WAIT_IDLE
        checks++;
        if ({rqst_oe_n, arbcy_n, start_n_o} !== 3'b011) begin
            errors++; $display("FAIL basic_wait_idle: got %b want 011",
                               {rqst_oe_n, arbcy_n, start_n_o});
        end
        step(); // START
        checks++;
        if ({start_n_o, dir, rqst_oe_n} !== 3'b011) begin
            errors++; $display("FAIL basic_start: got %b want 011", {start_n_o, dir, rqst_oe_n});
        end
        step(); // WAIT_ACK
        checks++;
        if ({start_n_o, dir} !== 2'b10) begin
            errors++; $display("FAIL basic_start_one_clock: got %b want 10", {start_n_o, dir});
        end
        step();
        ack_n = 0;
        tm_n = 2'b11;
        step(); // DONE
        checks++;
        if ({done, err, status} !== 4'b1000) begin
            errors++; $display("FAIL basic_done: got %b want 1000", {done, err, status});
        end
        req = 0;
        ack_n = 1;
        step();
        checks++;
        if ({done, busy} !== 2'b00) begin
            errors++; $display("FAIL basic_done_pulse: got %b want 00", {done, busy});
        end
    endtask

    task automatic test_fair();
        logic [3:0] res;
        int starts;
        defaults();
        rqst_n = 0;
        req = 1;
        step();
        for (int c = 0; c < 10; c++) begin
            step();
            checks++;
            if ({rqst_oe_n, arbcy_n} !== 2'b11) begin
                errors++; $display("FAIL fair_hold%0d: got %b want 11", c, {rqst_oe_n, arbcy_n});
            end
        end
        rqst_n = 1;
        step();
        checks++;
        if ({rqst_oe_n, arbcy_n} !== 2'b00) begin
            errors++; $display("FAIL fair_release_arb: got %b want 00", {rqst_oe_n, arbcy_n});
        end
        finish_txn(2'b11, res, starts);
        checks++;
        if (res !== 4'b1000) begin
            errors++; $display("FAIL fair_txn_done: got %b want 1000", res);
        end
    endtask

    task automatic test_regrant();
        logic [3:0] res;
        int starts;
        defaults();
        grant = 0;
        req = 1;
        step(); // FAIR
        for (int c = 0; c < 4; c++) begin
            if (c == 3) grant = 1;
            step(); // ARB, ARB, re-contest ARB, ARB
            checks++;
            if ({rqst_oe_n, arbcy_n} !== 2'b00) begin
                errors++; $display("FAIL regrant_arb%0d: got %b want 00", c, {rqst_oe_n, arbcy_n});
            end
        end
        step(); // WAIT_IDLE
        checks++;
        if ({arbcy_n, rqst_oe_n, start_n_o} !== 3'b101) begin
            errors++; $display("FAIL regrant_wait_idle: got %b want 101",
                               {arbcy_n, rqst_oe_n, start_n_o});
        end
        finish_txn(2'b11, res, starts);
        checks++;
        if (starts != 1 || res !== 4'b1000) begin
            errors++; $display("FAIL regrant_single_start: got starts=%0d res=%b want 1 1000",
                               starts, res);
        end
    endtask

    task automatic test_foreign();
        logic [3:0] res;
        int starts;
        defaults();
        req = 1;
        start_n = 0; // foreign START seen on the same edge we leave IDLE
        step();
        start_n = 1;
        repeat (3) step(); // ARB, ARB, WAIT_IDLE
        for (int c = 0; c < 2; c++) begin
            checks++;
            if ({start_n_o, arbcy_n} !== 2'b11) begin
                errors++; $display("FAIL foreign_hold%0d: got %b want 11", c, {start_n_o, arbcy_n});
            end
            step();
        end
        ack_n = 0;
        checks++;
        if (start_n_o !== 1'b1) begin
            errors++; $display("FAIL foreign_before_ack: got %b want 1", start_n_o);
        end
        step(); // ack observed: still WAIT_IDLE
        ack_n = 1;
        checks++;
        if (start_n_o !== 1'b1) begin
            errors++; $display("FAIL foreign_ack_cycle: got %b want 1", start_n_o);
        end
        step();
        checks++;
        if (start_n_o !== 1'b0) begin
            errors++; $display("FAIL foreign_start_after_ack: got %b want 0", start_n_o);
        end
        finish_txn(2'b11, res, starts);
        checks++;
        if (res !== 4'b1000) begin
            errors++; $display("FAIL foreign_txn_done: got %b want 1000", res);
        end
    endtask

    task automatic test_timeout();
        bit seen;
        int n;
        logic [3:0] res;
        int starts;
        defaults();
        req = 1;
        wait_start(seen);
        n = -1;
        for (int i = 0; i < 300; i++) begin
            step();
            if (done === 1'b1) begin
                n = i + 1;
                break;
            end
        end
        checks++;
        if (!seen || n != 256) begin
            errors++; $display("FAIL timeout_latency: got start=%0d clocks=%0d want 1 256", seen, n);
        end
        checks++;
        if ({err, status} !== 3'b111) begin
            errors++; $display("FAIL timeout_status: got %b want 111", {err, status});
        end
        req = 0;
        step();
        // Retry status: tm_n=01 -> captured 10.
        req = 1;
        finish_txn(2'b01, res, starts);
        checks++;
        if (res !== 4'b1110) begin
            errors++; $display("FAIL retry_status: got %b want 1110", res);
        end
    endtask

    task automatic test_lock();
        bit seen;
        defaults();
        lock = 1;
        req = 1;
        wait_start(seen);
        checks++;
        if (!seen || rqst_oe_n !== 1'b0) begin
            errors++; $display("FAIL lock_start_rqst: got start=%0d rqst_oe_n=%b want 1 0",
                               seen, rqst_oe_n);
        end
        step();
        ack_n = 0;
        step(); // DONE, req still high
        ack_n = 1;
        checks++;
        if ({done, rqst_oe_n} !== 2'b10) begin
            errors++; $display("FAIL lock_done1: got %b want 10", {done, rqst_oe_n});
        end
        step(); // straight to WAIT_IDLE
        checks++;
        if ({arbcy_n, rqst_oe_n, start_n_o, busy} !== 4'b1011) begin
            errors++; $display("FAIL lock_wait_idle: got %b want 1011",
                               {arbcy_n, rqst_oe_n, start_n_o, busy});
        end
        step(); // second START
        checks++;
        if ({start_n_o, rqst_oe_n, arbcy_n} !== 3'b001) begin
            errors++; $display("FAIL lock_start2: got %b want 001", {start_n_o, rqst_oe_n, arbcy_n});
        end
        lock = 0;
        step();
        ack_n = 0;
        step();
        checks++;
        if ({done, rqst_oe_n} !== 2'b10) begin
            errors++; $display("FAIL lock_done2: got %b want 10", {done, rqst_oe_n});
        end
        req = 0;
        ack_n = 1;
        step();
        checks++;
        if ({rqst_oe_n, busy} !== 2'b10) begin
            errors++; $display("FAIL lock_release: got %b want 10", {rqst_oe_n, busy});
        end
    endtask

    task automatic test_abort();
        defaults();
        req = 1;
        repeat (2) step(); // FAIR, ARB
        checks++;
        if (arbcy_n !== 1'b0) begin
            errors++; $display("FAIL abort_in_arb: got %b want 0", arbcy_n);
        end
        req = 0;
        step();
        checks++;
        if ({rqst_oe_n, arbcy_n, busy, done} !== 4'b1100) begin
            errors++; $display("FAIL abort_release: got %b want 1100",
                               {rqst_oe_n, arbcy_n, busy, done});
        end
        step();
        checks++;
        if (done !== 1'b0) begin
            errors++; $display("FAIL abort_no_done: got %b want 0", done);
        end
    endtask

    task automatic test_reset_mid();
        bit seen;
        defaults();
        req = 1;
        wait_start(seen);
        step(); // WAIT_ACK
        checks++;
        if (!seen || {busy, start_n_o} !== 2'b11) begin
            errors++; $display("FAIL rstmid_in_wait_ack: got start=%0d %b want 1 11",
                               seen, {busy, start_n_o});
        end
        rst = 1;
        step();
        checks++;
        if (outs() !== RST_VEC) begin
            errors++; $display("FAIL rstmid_values: got %b want %b", outs(), RST_VEC);
        end
        rst = 0;
        req = 0;
        step();
        checks++;
        if (outs() !== RST_VEC) begin
            errors++; $display("FAIL rstmid_stays_idle: got %b want %b", outs(), RST_VEC);
        end
    endtask

    initial begin
        rst = 1;
        defaults();
        @(negedge clk);
        test_reset();
        test_basic();
        test_fair();
        test_regrant();
        test_foreign();
        test_timeout();
        test_lock();
        test_abort();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
